// File: rtl/pipeline_hazard_controller.sv
// Hazard and flow control for a 5-stage ARM-style pipeline: load-use stalls, operand forwarding,
// condition-code evaluation against registered NZCV, branch flush and saturating debug counters.
module pipeline_hazard_controller #(
  parameter int unsigned RA_W  = 4,
  parameter int unsigned CNT_W = 16
) (
  input  logic             CLK,
  input  logic             CLR,
  input  logic [RA_W-1:0]  ID_Rn,
  input  logic [RA_W-1:0]  ID_Rm,
  input  logic [RA_W-1:0]  ID_Rd,
  input  logic             ID_use_Rn,
  input  logic             ID_use_Rm,
  input  logic             ID_use_Rd,
  input  logic             ID_B_instr,
  input  logic [3:0]       ID_cond,
  input  logic [RA_W-1:0]  EX_Rd,
  input  logic [RA_W-1:0]  MEM_Rd,
  input  logic [RA_W-1:0]  WB_Rd,
  input  logic             EX_RF_enable,
  input  logic             MEM_RF_enable,
  input  logic             WB_RF_enable,
  input  logic             EX_Load_Inst,
  input  logic             EX_S,
  input  logic [3:0]       EX_flags,
  output logic             PC_Ld,
  output logic             IFID_Ld,
  output logic             IFID_flush,
  output logic             nop_sel,
  output logic             PC_src,
  output logic [1:0]       fwd_A,
  output logic [1:0]       fwd_B,
  output logic [1:0]       fwd_C,
  output logic [3:0]       flags,
  output logic             cond_true,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam logic [RA_W-1:0]  PcReg  = RA_W'(15);
  localparam logic [CNT_W-1:0] CntMax = '1;

  logic [3:0]       flags_q, flags_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  logic       hz;
  logic       bt;
  logic       ex_fwd_ok;
  logic [3:0] eff_flags;
  logic       flag_n, flag_z, flag_c, flag_v;

  // Priority EX > MEM > WB; the PC (R15) is never forwarded.
  function automatic logic [1:0] fwd_sel(
    input logic [RA_W-1:0] src,
    input logic            used,
    input logic            ex_ok,
    input logic [RA_W-1:0] ex_rd,
    input logic            mem_en,
    input logic [RA_W-1:0] mem_rd,
    input logic            wb_en,
    input logic [RA_W-1:0] wb_rd
  );
    logic [1:0] sel;
    sel = 2'b00;
    if (used && (src != PcReg)) begin
      if (ex_ok && (ex_rd == src)) begin
        sel = 2'b01;
      end else if (mem_en && (mem_rd == src)) begin
        sel = 2'b10;
      end else if (wb_en && (wb_rd == src)) begin
        sel = 2'b11;
      end
    end
    return sel;
  endfunction

  // A load still in EX has no data yet, so it can only be waited on, not forwarded.
  assign ex_fwd_ok = EX_RF_enable & ~EX_Load_Inst;

  assign hz = EX_Load_Inst & EX_RF_enable &
              ((ID_use_Rn & (ID_Rn == EX_Rd)) |
               (ID_use_Rm & (ID_Rm == EX_Rd)) |
               (ID_use_Rd & (ID_Rd == EX_Rd)));

  // Flag-setting instruction in EX feeds the branch decision in the same cycle.
  assign eff_flags = EX_S ? EX_flags : flags_q;
  assign flag_n    = eff_flags[3];
  assign flag_z    = eff_flags[2];
  assign flag_c    = eff_flags[1];
  assign flag_v    = eff_flags[0];

  always_comb begin
    cond_true = 1'b0;
    unique case (ID_cond)
      4'b0000: cond_true = flag_z;
      4'b0001: cond_true = ~flag_z;
      4'b0010: cond_true = flag_c;
      4'b0011: cond_true = ~flag_c;
      4'b0100: cond_true = flag_n;
      4'b0101: cond_true = ~flag_n;
      4'b0110: cond_true = flag_v;
      4'b0111: cond_true = ~flag_v;
      4'b1000: cond_true = flag_c & ~flag_z;
      4'b1001: cond_true = ~flag_c | flag_z;
      4'b1010: cond_true = (flag_n == flag_v);
      4'b1011: cond_true = (flag_n != flag_v);
      4'b1100: cond_true = ~flag_z & (flag_n == flag_v);
      4'b1101: cond_true = flag_z | (flag_n != flag_v);
      4'b1110: cond_true = 1'b1;
      4'b1111: cond_true = 1'b0;
    endcase
  end

  // A stall suppresses the branch; it re-evaluates once the load has moved on.
  assign bt = ID_B_instr & cond_true & ~hz;

  always_comb begin
    flags_d     = flags_q;
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (EX_S) begin
      flags_d = EX_flags;
    end
    if (hz && (stall_cnt_q != CntMax)) begin
      stall_cnt_d = stall_cnt_q + 1'b1;
    end
    if (bt && (flush_cnt_q != CntMax)) begin
      flush_cnt_d = flush_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (CLR) begin
      flags_q     <= 4'b0000;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      flags_q     <= flags_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  always_comb begin
    PC_Ld      = ~hz;
    IFID_Ld    = ~hz;
    nop_sel    = hz;
    IFID_flush = bt;
    PC_src     = bt;
    fwd_A = fwd_sel(ID_Rn, ID_use_Rn, ex_fwd_ok, EX_Rd, MEM_RF_enable, MEM_Rd,
                    WB_RF_enable, WB_Rd);
    fwd_B = fwd_sel(ID_Rm, ID_use_Rm, ex_fwd_ok, EX_Rd, MEM_RF_enable, MEM_Rd,
                    WB_RF_enable, WB_Rd);
    fwd_C = fwd_sel(ID_Rd, ID_use_Rd, ex_fwd_ok, EX_Rd, MEM_RF_enable, MEM_Rd,
                    WB_RF_enable, WB_Rd);
  end

  assign flags     = flags_q;
  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;

  // A bubble and a squash never coincide; the stall always wins.
  a_stall_excludes_flush: assert property (@(posedge CLK) disable iff (CLR)
    !(nop_sel && IFID_flush));
  a_stall_freezes_pc: assert property (@(posedge CLK) disable iff (CLR)
    nop_sel |-> (!PC_Ld && !IFID_Ld && !PC_src));

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Randomised and directed checks of pipeline_hazard_controller against a behavioural model.
module tb_pipeline_hazard_controller;

  logic       clk = 1'b0;
  logic       clr;
  logic [3:0] id_rn, id_rm, id_rd, id_cond, ex_rd, mem_rd, wb_rd, ex_flags;
  logic       use_rn, use_rm, use_rd, id_b;
  logic       ex_en, mem_en, wb_en, ex_load, ex_s;

  logic        pc_ld, ifid_ld, ifid_flush, nop_sel, pc_src, cond_true;
  logic [1:0]  fwd_a, fwd_b, fwd_c;
  logic [3:0]  flags;
  logic [15:0] stall_cnt, flush_cnt;

  logic        pc_ld4, ifid_ld4, ifid_flush4, nop_sel4, pc_src4, cond_true4;
  logic [1:0]  fwd_a4, fwd_b4, fwd_c4;
  logic [3:0]  flags4;
  logic [3:0]  stall_cnt4, flush_cnt4;

  int n_vec = 0;
  int n_err = 0;

  // Model state
  logic [3:0] m_flags;
  int m_stall, m_flush, m_stall4, m_flush4;

  typedef struct packed {
    logic       pc_ld;
    logic       ifid_ld;
    logic       ifid_flush;
    logic       nop_sel;
    logic       pc_src;
    logic [1:0] fa;
    logic [1:0] fb;
    logic [1:0] fc;
    logic       ct;
  } comb_t;

  always #5 clk = ~clk;

  pipeline_hazard_controller #(.RA_W(4), .CNT_W(16)) dut (
    .CLK(clk), .CLR(clr),
    .ID_Rn(id_rn), .ID_Rm(id_rm), .ID_Rd(id_rd),
    .ID_use_Rn(use_rn), .ID_use_Rm(use_rm), .ID_use_Rd(use_rd),
    .ID_B_instr(id_b), .ID_cond(id_cond),
    .EX_Rd(ex_rd), .MEM_Rd(mem_rd), .WB_Rd(wb_rd),
    .EX_RF_enable(ex_en), .MEM_RF_enable(mem_en), .WB_RF_enable(wb_en),
    .EX_Load_Inst(ex_load), .EX_S(ex_s), .EX_flags(ex_flags),
    .PC_Ld(pc_ld), .IFID_Ld(ifid_ld), .IFID_flush(ifid_flush), .nop_sel(nop_sel),
    .PC_src(pc_src), .fwd_A(fwd_a), .fwd_B(fwd_b), .fwd_C(fwd_c),
    .flags(flags), .cond_true(cond_true), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  pipeline_hazard_controller #(.RA_W(4), .CNT_W(4)) dut4 (
    .CLK(clk), .CLR(clr),
    .ID_Rn(id_rn), .ID_Rm(id_rm), .ID_Rd(id_rd),
    .ID_use_Rn(use_rn), .ID_use_Rm(use_rm), .ID_use_Rd(use_rd),
    .ID_B_instr(id_b), .ID_cond(id_cond),
    .EX_Rd(ex_rd), .MEM_Rd(mem_rd), .WB_Rd(wb_rd),
    .EX_RF_enable(ex_en), .MEM_RF_enable(mem_en), .WB_RF_enable(wb_en),
    .EX_Load_Inst(ex_load), .EX_S(ex_s), .EX_flags(ex_flags),
    .PC_Ld(pc_ld4), .IFID_Ld(ifid_ld4), .IFID_flush(ifid_flush4), .nop_sel(nop_sel4),
    .PC_src(pc_src4), .fwd_A(fwd_a4), .fwd_B(fwd_b4), .fwd_C(fwd_c4),
    .flags(flags4), .cond_true(cond_true4), .stall_cnt(stall_cnt4), .flush_cnt(flush_cnt4)
  );

  // ---------------- reference model ----------------
  function automatic bit m_cond(input logic [3:0] c, input logic [3:0] f);
    bit n, z, cy, v, base;
    n = f[3]; z = f[2]; cy = f[1]; v = f[0];
    if (c == 4'b1111) return 1'b0;
    case (c[3:1])
      3'd0: base = z;
      3'd1: base = cy;
      3'd2: base = n;
      3'd3: base = v;
      3'd4: base = cy && !z;
      3'd5: base = (n == v);
      3'd6: base = !z && (n == v);
      default: base = 1'b1;
    endcase
    return c[0] ? !base : base;
  endfunction

  function automatic bit m_hz();
    return ex_load && ex_en &&
           ((use_rn && id_rn == ex_rd) || (use_rm && id_rm == ex_rd) ||
            (use_rd && id_rd == ex_rd));
  endfunction

  function automatic logic [1:0] m_fwd(input logic [3:0] src, input bit used);
    logic [3:0] rd [3];
    bit         en [3];
    rd[0] = ex_rd;  en[0] = ex_en && !ex_load;
    rd[1] = mem_rd; en[1] = mem_en;
    rd[2] = wb_rd;  en[2] = wb_en;
    if (!used || src == 4'd15) return 2'b00;
    for (int i = 0; i < 3; i++) begin
      if (en[i] && rd[i] == src) return 2'(i + 1);
    end
    return 2'b00;
  endfunction

  function automatic comb_t model_comb();
    comb_t e;
    bit hz, ct, bt;
    hz = m_hz();
    ct = m_cond(id_cond, ex_s ? ex_flags : m_flags);
    bt = id_b && ct && !hz;
    e.pc_ld = !hz; e.ifid_ld = !hz; e.nop_sel = hz;
    e.ifid_flush = bt; e.pc_src = bt; e.ct = ct;
    e.fa = m_fwd(id_rn, use_rn);
    e.fb = m_fwd(id_rm, use_rm);
    e.fc = m_fwd(id_rd, use_rd);
    return e;
  endfunction

  function automatic comb_t observed();
    return {pc_ld, ifid_ld, ifid_flush, nop_sel, pc_src, fwd_a, fwd_b, fwd_c, cond_true};
  endfunction

  // Advance one clock edge, updating the model from the inputs seen before the edge.
  task automatic tick();
    comb_t e;
    bit    hz;
    e  = model_comb();
    hz = m_hz();
    @(posedge clk);
    if (clr) begin
      m_flags = 4'b0000; m_stall = 0; m_flush = 0; m_stall4 = 0; m_flush4 = 0;
    end else begin
      if (ex_s) m_flags = ex_flags;
      if (hz) begin
        if (m_stall < 65535) m_stall++;
        if (m_stall4 < 15) m_stall4++;
      end
      if (e.pc_src) begin
        if (m_flush < 65535) m_flush++;
        if (m_flush4 < 15) m_flush4++;
      end
    end
    #1;
  endtask

  task automatic clear_inputs();
    clr = 1'b0;
    id_rn = 4'd0; id_rm = 4'd0; id_rd = 4'd0; id_cond = 4'd0;
    ex_rd = 4'd0; mem_rd = 4'd0; wb_rd = 4'd0; ex_flags = 4'd0;
    use_rn = 1'b0; use_rm = 1'b0; use_rd = 1'b0; id_b = 1'b0;
    ex_en = 1'b0; mem_en = 1'b0; wb_en = 1'b0; ex_load = 1'b0; ex_s = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    clear_inputs();
    ex_s = 1'b1; ex_flags = 4'b1111;
    tick();
    ex_s = 1'b0;
    ex_load = 1'b1; ex_en = 1'b1; ex_rd = 4'd5; id_rn = 4'd5; use_rn = 1'b1;
    repeat (7) tick();
    n_vec++;
    if (stall_cnt !== 16'd7 || flags !== 4'b1111) begin
      n_err++;
      $display("FAIL pre_reset: stall_cnt=%0d flags=%b expected 7 1111", stall_cnt, flags);
    end
    clear_inputs();
    clr = 1'b1;
    tick();
    clr = 1'b0;
    #1;
    n_vec++;
    if (flags !== 4'b0000) begin
      n_err++; $display("FAIL reset_flags: got %b expected 0000", flags);
    end
    n_vec++;
    if (stall_cnt !== 16'd0 || flush_cnt !== 16'd0 || stall_cnt4 !== 4'd0) begin
      n_err++;
      $display("FAIL reset_cnt: stall=%0d flush=%0d stall4=%0d expected 0 0 0",
               stall_cnt, flush_cnt, stall_cnt4);
    end
    n_vec++;
    if (pc_ld !== 1'b1 || nop_sel !== 1'b0 || ifid_ld !== 1'b1 || ifid_flush !== 1'b0 ||
        pc_src !== 1'b0 || fwd_a !== 2'b00 || fwd_b !== 2'b00 || fwd_c !== 2'b00) begin
      n_err++;
      $display("FAIL reset_comb: pc_ld=%b ifid_ld=%b nop=%b flush=%b src=%b fwd=%b%b%b",
               pc_ld, ifid_ld, nop_sel, ifid_flush, pc_src, fwd_a, fwd_b, fwd_c);
    end
  endtask

  task automatic test_load_use();
    clear_inputs();
    ex_load = 1'b1; ex_en = 1'b1; ex_rd = 4'd5; id_rn = 4'd5; use_rn = 1'b1;
    #1;
    n_vec++;
    if (pc_ld !== 1'b0 || ifid_ld !== 1'b0 || nop_sel !== 1'b1 || ifid_flush !== 1'b0) begin
      n_err++;
      $display("FAIL load_use_stall: pc_ld=%b ifid_ld=%b nop=%b flush=%b expected 0 0 1 0",
               pc_ld, ifid_ld, nop_sel, ifid_flush);
    end
    tick();
    n_vec++;
    if (stall_cnt !== 16'd1) begin
      n_err++; $display("FAIL load_use_cnt: stall_cnt=%0d expected 1", stall_cnt);
    end
    use_rn = 1'b0;
    #1;
    n_vec++;
    if (pc_ld !== 1'b1 || nop_sel !== 1'b0 || ifid_ld !== 1'b1) begin
      n_err++;
      $display("FAIL load_use_unused: pc_ld=%b nop=%b expected 1 0", pc_ld, nop_sel);
    end
  endtask

  task automatic test_forward();
    clear_inputs();
    ex_rd = 4'd3; mem_rd = 4'd3; wb_rd = 4'd3;
    ex_en = 1'b1; mem_en = 1'b1; wb_en = 1'b1;
    id_rm = 4'd3; use_rm = 1'b1; id_rn = 4'd3; use_rn = 1'b0;
    #1;
    n_vec++;
    if (fwd_b !== 2'b01) begin n_err++; $display("FAIL fwd_ex: got %b expected 01", fwd_b); end
    n_vec++;
    if (fwd_a !== 2'b00) begin n_err++; $display("FAIL fwd_unused: got %b expected 00", fwd_a); end
    ex_load = 1'b1;
    #1;
    n_vec++;
    if (fwd_b !== 2'b10) begin n_err++; $display("FAIL fwd_ex_load: got %b expected 10", fwd_b); end
    ex_load = 1'b0; ex_en = 1'b0;
    #1;
    n_vec++;
    if (fwd_b !== 2'b10) begin n_err++; $display("FAIL fwd_mem: got %b expected 10", fwd_b); end
    mem_en = 1'b0;
    #1;
    n_vec++;
    if (fwd_b !== 2'b11) begin n_err++; $display("FAIL fwd_wb: got %b expected 11", fwd_b); end
    ex_rd = 4'd15; mem_rd = 4'd15; wb_rd = 4'd15; ex_en = 1'b1; mem_en = 1'b1;
    id_rm = 4'd15;
    #1;
    n_vec++;
    if (fwd_b !== 2'b00) begin n_err++; $display("FAIL fwd_r15: got %b expected 00", fwd_b); end
  endtask

  task automatic test_subs_bne();
    clear_inputs();
    ex_s = 1'b1; ex_flags = 4'b0100; id_b = 1'b1; id_cond = 4'b0001;
    #1;
    n_vec++;
    if (cond_true !== 1'b0 || pc_src !== 1'b0 || ifid_flush !== 1'b0) begin
      n_err++;
      $display("FAIL bne_fwd_z: cond=%b src=%b flush=%b expected 0 0 0",
               cond_true, pc_src, ifid_flush);
    end
    tick();
    n_vec++;
    if (flags !== 4'b0100) begin n_err++; $display("FAIL subs_flags: got %b expected 0100", flags); end
    ex_s = 1'b0;
    #1;
    n_vec++;
    if (cond_true !== 1'b0) begin
      n_err++; $display("FAIL bne_reg_z: cond=%b expected 0", cond_true);
    end
    ex_s = 1'b1; ex_flags = 4'b0000;
    #1;
    n_vec++;
    if (pc_src !== 1'b1 || ifid_flush !== 1'b1 || pc_ld !== 1'b1 || nop_sel !== 1'b0) begin
      n_err++;
      $display("FAIL bne_taken: src=%b flush=%b pc_ld=%b nop=%b expected 1 1 1 0",
               pc_src, ifid_flush, pc_ld, nop_sel);
    end
    tick();
    n_vec++;
    if (flush_cnt !== 16'(m_flush) || m_flush == 0) begin
      n_err++; $display("FAIL bne_cnt: flush_cnt=%0d expected %0d", flush_cnt, m_flush);
    end
  endtask

  task automatic test_simultaneous();
    clear_inputs();
    ex_load = 1'b1; ex_en = 1'b1; ex_rd = 4'd7; id_rm = 4'd7; use_rm = 1'b1;
    id_b = 1'b1; id_cond = 4'b1110;
    #1;
    n_vec++;
    if (nop_sel !== 1'b1 || ifid_flush !== 1'b0 || pc_src !== 1'b0) begin
      n_err++;
      $display("FAIL simul_stall: nop=%b flush=%b src=%b expected 1 0 0",
               nop_sel, ifid_flush, pc_src);
    end
    tick();
    ex_load = 1'b0; ex_en = 1'b1;
    #1;
    n_vec++;
    if (pc_src !== 1'b1 || ifid_flush !== 1'b1 || nop_sel !== 1'b0) begin
      n_err++;
      $display("FAIL simul_branch: src=%b flush=%b nop=%b expected 1 1 0",
               pc_src, ifid_flush, nop_sel);
    end
    tick();
  endtask

  task automatic test_saturation();
    clear_inputs();
    clr = 1'b1;
    tick();
    clr = 1'b0;
    ex_load = 1'b1; ex_en = 1'b1; ex_rd = 4'd2; id_rd = 4'd2; use_rd = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      n_vec++;
      if (stall_cnt4 !== 4'((i + 1 > 15) ? 15 : i + 1) || stall_cnt !== 16'(i + 1)) begin
        n_err++;
        $display("FAIL sat_step%0d: stall4=%0d stall16=%0d expected %0d %0d", i, stall_cnt4,
                 stall_cnt, (i + 1 > 15) ? 15 : i + 1, i + 1);
      end
    end
    n_vec++;
    if (stall_cnt4 !== 4'd15) begin
      n_err++; $display("FAIL sat_hold: stall4=%0d expected 15", stall_cnt4);
    end
  endtask

  function automatic logic [3:0] rnd_reg();
    return ($urandom_range(0, 7) == 0) ? 4'd15 : 4'($urandom_range(0, 3));
  endfunction

  task automatic test_random();
    comb_t e, o;
    for (int i = 0; i < 400; i++) begin
      clr = ($urandom_range(0, 49) == 0);
      id_rn = rnd_reg(); id_rm = rnd_reg(); id_rd = rnd_reg();
      ex_rd = rnd_reg(); mem_rd = rnd_reg(); wb_rd = rnd_reg();
      use_rn = 1'($urandom); use_rm = 1'($urandom); use_rd = 1'($urandom);
      ex_en = 1'($urandom); mem_en = 1'($urandom); wb_en = 1'($urandom);
      ex_load = ($urandom_range(0, 2) == 0);
      ex_s = 1'($urandom); ex_flags = 4'($urandom);
      id_b = ($urandom_range(0, 2) != 0); id_cond = 4'($urandom);
      #1;
      e = model_comb();
      o = observed();
      n_vec++;
      if (o !== e) begin
        n_err++; $display("FAIL rand_comb%0d: got %h expected %h", i, o, e);
      end
      tick();
      n_vec++;
      if (flags !== m_flags || stall_cnt !== 16'(m_stall) || flush_cnt !== 16'(m_flush) ||
          stall_cnt4 !== 4'(m_stall4) || flush_cnt4 !== 4'(m_flush4)) begin
        n_err++;
        $display("FAIL rand_state%0d: flags=%b s=%0d f=%0d s4=%0d f4=%0d expected %b %0d %0d %0d %0d",
                 i, flags, stall_cnt, flush_cnt, stall_cnt4, flush_cnt4,
                 m_flags, m_stall, m_flush, m_stall4, m_flush4);
      end
    end
  endtask

  initial begin
    clear_inputs();
    m_flags = 4'b0000; m_stall = 0; m_flush = 0; m_stall4 = 0; m_flush4 = 0;
    clr = 1'b1;
    tick();
    clr = 1'b0;
    test_reset();
    test_load_use();
    test_forward();
    test_subs_bne();
    test_simultaneous();
    test_saturation();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
